di_reg_terminal: RTL and testbench

DI_REG_TERMINAL -- requirements
Module: di_reg_terminal

---
 rtl/di_reg_terminal_if.sv | 28 ++
 rtl/di_reg_terminal.sv | 168 ++++++++++++++++
 tb/tb_di_reg_terminal.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/di_reg_terminal_if.sv
// Host-side bus of the register terminal: selection, burst setup, read and write handshakes.
interface di_reg_if;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic [31:0] di_len;
  logic        di_read_mode;
  logic        di_read_req;
  logic        di_read;
  logic        di_read_rdy;
  logic [31:0] di_reg_datao;
  logic        di_write_mode;
  logic        di_write;
  logic [31:0] di_reg_datai;
  logic        di_write_rdy;
  logic [15:0] di_transfer_status;

  modport master (
    output di_term_addr, di_reg_addr, di_len, di_read_mode, di_read_req, di_read,
           di_write_mode, di_write, di_reg_datai,
    input  di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
  );

  modport slave (
    input  di_term_addr, di_reg_addr, di_len, di_read_mode, di_read_req, di_read,
           di_write_mode, di_write, di_reg_datai,
    output di_read_rdy, di_reg_datao, di_write_rdy, di_transfer_status
  );
endinterface

// File: rtl/di_reg_terminal.sv
// Addressable RW register bank with burst read/write handshakes and a read-only hw_status word.
// Define DI_REG_TERMINAL_ADDR_ERR_EN to report out-of-range accesses in di_transfer_status.
module di_reg_terminal #(
  parameter logic [15:0] TERM_ADDR  = 16'h0010,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    ifclk,
  input  logic                    resetb,
  di_reg_if.slave                 bus,
  input  logic [31:0]             hw_status,
  output logic [32*NUM_REGS-1:0]  regs_flat
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = 4;
`ifdef DI_REG_TERMINAL_ADDR_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RDY, WR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        datao_q, datao_d;
  logic [15:0]        status_q, status_d;
  logic               read_rdy_q, read_rdy_d;
  logic               write_rdy_q, write_rdy_d;
  logic               rmode_q, wmode_q;
  logic [31:0]        regs_q [NUM_REGS];

  logic               sel_c;
  logic               wmode_rise_c, wmode_fall_c, rmode_fall_c;
  logic               reg_we_c;
  logic [31:0]        rd_data_c;
  logic               rd_oor_c;

  assign sel_c        = (bus.di_term_addr == TERM_ADDR);
  assign wmode_rise_c = bus.di_write_mode & ~wmode_q;
  assign wmode_fall_c = ~bus.di_write_mode & wmode_q;
  assign rmode_fall_c = ~bus.di_read_mode & rmode_q;
  assign rd_oor_c     = (addr_q > 32'(NUM_REGS));

  // Read decode: bank, then hw_status at NUM_REGS, zero beyond
  always_comb begin
    rd_data_c = 32'h0;
    if (addr_q < 32'(NUM_REGS)) begin
      rd_data_c = regs_q[addr_q[IDX_W-1:0]];
    end else if (addr_q == 32'(NUM_REGS)) begin
      rd_data_c = hw_status;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    datao_d  = datao_q;
    status_d = status_q;
    reg_we_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_c && bus.di_read_req && (bus.di_len != 32'h0)) begin
          state_d  = RD_WAIT;
          addr_d   = bus.di_reg_addr;
          rem_d    = bus.di_len;
          cnt_d    = CNT_W'(RD_LATENCY);
          status_d = 16'h0000;
        end else if (sel_c && wmode_rise_c) begin
          state_d  = WR;
          addr_d   = bus.di_reg_addr;
          status_d = 16'h0000;
        end
      end
      RD_WAIT: begin
        if (rmode_fall_c) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RD_RDY;
          datao_d = rd_data_c;
          if (ERR_EN && rd_oor_c) status_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_RDY: begin
        if (rmode_fall_c) begin
          state_d = IDLE;
        end else if (sel_c && read_rdy_q && bus.di_read) begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 32'd1;
          if (rem_q > 32'd1) begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LATENCY);
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR: begin
        if (wmode_fall_c) begin
          state_d = IDLE;
        end else if (sel_c && write_rdy_q && bus.di_write) begin
          addr_d = addr_q + 32'd1;
          if (addr_q < 32'(NUM_REGS)) begin
            reg_we_c = 1'b1;
          end else if (ERR_EN) begin
            status_d[1] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    read_rdy_d  = sel_c && (state_d == RD_RDY);
    write_rdy_d = sel_c && (state_d == WR);
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      datao_q     <= '0;
      status_q    <= '0;
      read_rdy_q  <= 1'b0;
      write_rdy_q <= 1'b0;
      rmode_q     <= 1'b0;
      wmode_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      datao_q     <= datao_d;
      status_q    <= status_d;
      read_rdy_q  <= read_rdy_d;
      write_rdy_q <= write_rdy_d;
      rmode_q     <= bus.di_read_mode;
      wmode_q     <= bus.di_write_mode;
    end
  end

  // Register bank
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (reg_we_c) begin
      regs_q[addr_q[IDX_W-1:0]] <= bus.di_reg_datai;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_flat[32*g +: 32] = regs_q[g];
  end

  assign bus.di_read_rdy        = read_rdy_q;
  assign bus.di_write_rdy       = write_rdy_q;
  assign bus.di_reg_datao       = datao_q;
  assign bus.di_transfer_status = status_q;

endmodule

// File: tb/tb_di_reg_terminal.sv
// Directed bench for di_reg_terminal with default parameters (TERM_ADDR 16'h0010, 16 regs, RD_LATENCY 2).
module tb_di_reg_terminal;

  localparam int unsigned FW = 512;
  localparam logic [15:0] TERM = 16'h0010;
`ifdef DI_REG_TERMINAL_ADDR_ERR_EN
  localparam logic [15:0] ST_RD_OOR = 16'h0001;
  localparam logic [15:0] ST_WR_OOR = 16'h0002;
`else
  localparam logic [15:0] ST_RD_OOR = 16'h0000;
  localparam logic [15:0] ST_WR_OOR = 16'h0000;
`endif

  logic          ifclk = 1'b0;
  logic          resetb;
  logic [31:0]   hw_status;
  logic [FW-1:0] regs_flat;

  di_reg_if bus ();

  di_reg_terminal dut (
    .ifclk     (ifclk),
    .resetb    (resetb),
    .bus       (bus),
    .hw_status (hw_status),
    .regs_flat (regs_flat)
  );

  always #5 ifclk = ~ifclk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [16];
  logic [31:0] exp_q [$];
  logic [31:0] wr_q  [$];

  task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < 16; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge ifclk);
    #1;
  endtask

  // Burst write of wr_q starting at addr; model tracks in-range words only
  task automatic do_write(input logic [31:0] addr, input string tag);
    logic [31:0] a;
    a = addr;
    bus.di_term_addr  = TERM;
    bus.di_reg_addr   = addr;
    bus.di_write_mode = 1'b1;
    tick();
    check_val({tag, "_wrdy"}, FW'(bus.di_write_rdy), FW'(1));
    foreach (wr_q[i]) begin
      bus.di_reg_datai = wr_q[i];
      bus.di_write     = 1'b1;
      tick();
      if (a < 32'd16) model[a[3:0]] = wr_q[i];
      a = a + 32'd1;
    end
    bus.di_write      = 1'b0;
    bus.di_write_mode = 1'b0;
    tick();
    check_val({tag, "_wrdy_off"}, FW'(bus.di_write_rdy), FW'(0));
    check_val({tag, "_regs"}, regs_flat, model_flat());
  endtask

  // Burst read of exp_q.size() words from addr; rdy expected 3 cycles after each load
  task automatic rd_burst(input logic [31:0] addr, input string tag);
    int n;
    bus.di_term_addr = TERM;
    bus.di_reg_addr  = addr;
    bus.di_len       = 32'(exp_q.size());
    bus.di_read_mode = 1'b1;
    bus.di_read_req  = 1'b1;
    tick();
    bus.di_read_req = 1'b0;
    foreach (exp_q[i]) begin
      n = 0;
      while (!bus.di_read_rdy && n < 32) begin
        tick();
        n++;
      end
      check_val({tag, "_lat"}, FW'(n), FW'(3));
      check_val({tag, "_data"}, FW'(bus.di_reg_datao), FW'(exp_q[i]));
      if (i == 0) begin
        tick();
        check_val({tag, "_hold_rdy"}, FW'(bus.di_read_rdy), FW'(1));
        check_val({tag, "_hold_data"}, FW'(bus.di_reg_datao), FW'(exp_q[i]));
      end
      bus.di_read = 1'b1;
      tick();
      bus.di_read = 1'b0;
      check_val({tag, "_rdy_drop"}, FW'(bus.di_read_rdy), FW'(0));
    end
    bus.di_read_mode = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    resetb            = 1'b0;
    hw_status         = 32'h0;
    bus.di_term_addr  = 16'h0;
    bus.di_reg_addr   = 32'h0;
    bus.di_len        = 32'h0;
    bus.di_read_mode  = 1'b0;
    bus.di_read_req   = 1'b0;
    bus.di_read       = 1'b0;
    bus.di_write_mode = 1'b0;
    bus.di_write      = 1'b0;
    bus.di_reg_datai  = 32'h0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    repeat (3) tick();
    check_val("rst_read_rdy", FW'(bus.di_read_rdy), FW'(0));
    check_val("rst_write_rdy", FW'(bus.di_write_rdy), FW'(0));
    check_val("rst_datao", FW'(bus.di_reg_datao), FW'(0));
    check_val("rst_status", FW'(bus.di_transfer_status), FW'(0));
    check_val("rst_regs", regs_flat, '0);
    resetb = 1'b1;
    tick();

    // Single write then read of reg3
    wr_q = '{32'hCAFE0001};
    do_write(32'd3, "wr3");
    exp_q = '{32'hCAFE0001};
    rd_burst(32'd3, "rd3");
    check_val("rd3_status", FW'(bus.di_transfer_status), FW'(0));

    // Burst write regs0..3 then burst read
    wr_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(32'd0, "wrb");
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    rd_burst(32'd0, "rdb");
    check_val("rdb_idle_rdy", FW'(bus.di_read_rdy), FW'(0));

    // Wrong terminal: strobes ignored
    bus.di_term_addr  = 16'h0011;
    bus.di_reg_addr   = 32'd5;
    bus.di_write_mode = 1'b1;
    tick();
    check_val("wt_wrdy0", FW'(bus.di_write_rdy), FW'(0));
    bus.di_reg_datai = 32'hFFFF_FFFF;
    bus.di_write     = 1'b1;
    repeat (3) tick();
    check_val("wt_wrdy1", FW'(bus.di_write_rdy), FW'(0));
    bus.di_write      = 1'b0;
    bus.di_write_mode = 1'b0;
    bus.di_len        = 32'd1;
    bus.di_read_mode  = 1'b1;
    bus.di_read_req   = 1'b1;
    tick();
    bus.di_read_req = 1'b0;
    repeat (5) tick();
    check_val("wt_rrdy", FW'(bus.di_read_rdy), FW'(0));
    bus.di_read_mode = 1'b0;
    tick();
    check_val("wt_regs", regs_flat, model_flat());

    // hw_status read and ignored write
    hw_status = 32'h12345678;
    exp_q = '{32'h12345678};
    rd_burst(32'd16, "hw_rd");
    check_val("hw_rd_status", FW'(bus.di_transfer_status), FW'(0));
    wr_q = '{32'hDEADBEEF};
    do_write(32'd16, "hw_wr");
    check_val("hw_wr_status", FW'(bus.di_transfer_status), FW'(ST_WR_OOR));
    rd_burst(32'd16, "hw_rd2");

    // Abort during RD_WAIT
    bus.di_term_addr = TERM;
    bus.di_reg_addr  = 32'd1;
    bus.di_len       = 32'd1;
    bus.di_read_mode = 1'b1;
    bus.di_read_req  = 1'b1;
    tick();
    bus.di_read_req = 1'b0;
    tick();
    bus.di_read_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("abort_rdy", FW'(bus.di_read_rdy), FW'(0));
    end
    exp_q = '{32'd2};
    rd_burst(32'd1, "post_abort");

    // Out-of-range read, then status clears on next transfer
    exp_q = '{32'h0};
    rd_burst(32'd100, "oor");
    check_val("oor_status", FW'(bus.di_transfer_status), FW'(ST_RD_OOR));
    exp_q = '{32'd1};
    rd_burst(32'd0, "clr");
    check_val("clr_status", FW'(bus.di_transfer_status), FW'(0));

    // Address wraps from 0xFFFFFFFF to 0
    exp_q = '{32'h0, 32'd1};
    rd_burst(32'hFFFF_FFFF, "wrap");
    check_val("wrap_status", FW'(bus.di_transfer_status), FW'(ST_RD_OOR));

    // Simultaneous read request and write-mode edge: read wins
    bus.di_reg_addr   = 32'd2;
    bus.di_len        = 32'd1;
    bus.di_read_mode  = 1'b1;
    bus.di_write_mode = 1'b1;
    bus.di_read_req   = 1'b1;
    tick();
    bus.di_read_req = 1'b0;
    check_val("prec_wrdy", FW'(bus.di_write_rdy), FW'(0));
    n = 0;
    while (!bus.di_read_rdy && n < 32) begin
      tick();
      n++;
    end
    check_val("prec_lat", FW'(n), FW'(3));
    check_val("prec_data", FW'(bus.di_reg_datao), FW'(32'd3));
    bus.di_read = 1'b1;
    tick();
    bus.di_read       = 1'b0;
    bus.di_read_mode  = 1'b0;
    bus.di_write_mode = 1'b0;
    tick();
    check_val("prec_wrdy_end", FW'(bus.di_write_rdy), FW'(0));
    check_val("prec_regs", regs_flat, model_flat());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
